// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared state encoding and line-level constants for the serial frame receiver
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;
    localparam logic IDLE_BIT  = 1'b0;

endpackage

// File: rtl/serial_frame_receiver_frame_out_reg.sv
// rtl/serial_frame_receiver_frame_out_reg.sv - output word holding register with Ready handshake and sticky Overrun
module frame_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  Ready,
    output logic [DATA_WIDTH-1:0] Data,
    output logic                  Valid,
    output logic                  Overrun
);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Data    <= '0;
            Valid   <= 1'b0;
            Overrun <= 1'b0;
        end else if (load) begin
            // A held word that is not being taken this cycle wins; the new word is lost.
            if (Valid && !Ready) begin
                Overrun <= 1'b1;
            end else begin
                Data  <= load_data;
                Valid <= 1'b1;
            end
        end else if (Valid && Ready) begin
            Valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - deserialises start/data/parity/stop frames from an enabled serial bit stream
module serial_frame_receiver
    import serial_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit PARITY_EN  = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  sin,
    input  logic                  sin_en,
    output logic [DATA_WIDTH-1:0] Data,
    output logic                  Valid,
    input  logic                  Ready,
    output logic                  ParErr,
    output logic                  FrameErr,
    output logic                  Overrun
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_next;
    logic                  par_mis;
    logic                  par_mis_next;
    logic                  frame_good;
    logic                  par_err_set;
    logic                  frame_err_set;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            par_mis  <= 1'b0;
            ParErr   <= 1'b0;
            FrameErr <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            shreg    <= shreg_next;
            par_mis  <= par_mis_next;
            ParErr   <= par_err_set;
            FrameErr <= frame_err_set;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        shreg_next    = shreg;
        par_mis_next  = par_mis;
        frame_good    = 1'b0;
        par_err_set   = 1'b0;
        frame_err_set = 1'b0;

        if (sin_en) begin
            case (state)
                IDLE: begin
                    case (sin)
                        START_BIT: begin
                            state_next   = DATA;
                            cnt_next     = '0;
                            par_mis_next = 1'b0;
                        end
                        IDLE_BIT: state_next = IDLE;
                    endcase
                end
                DATA: begin
                    // LSB arrives first, so shifting right leaves it at bit 0 after the last bit.
                    shreg_next = {sin, shreg[DATA_WIDTH-1:1]};
                    cnt_next   = cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state_next = PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    par_mis_next = (sin != ^shreg);
                    state_next   = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (sin != STOP_BIT) begin
                        frame_err_set = 1'b1;
                    end else if (par_mis) begin
                        par_err_set = 1'b1;
                    end else begin
                        frame_good = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    frame_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_frame_out_reg (
        .Clock     (Clock),
        .Reset     (Reset),
        .load      (frame_good),
        .load_data (shreg),
        .Ready     (Ready),
        .Data      (Data),
        .Valid     (Valid),
        .Overrun   (Overrun)
    );

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - directed self-checking bench for serial_frame_receiver (parity and no-parity builds)
module tb_serial_frame_receiver;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       sin0, en0, rdy0, val0, pe0, fe0, ov0;
    logic [7:0] d0;
    logic       sin1, en1, rdy1, val1, pe1, fe1, ov1;
    logic [7:0] d1;

    int total = 0;
    int fails = 0;
    int tgt   = 0;

    always #5 Clock = ~Clock;

    serial_frame_receiver #(.DATA_WIDTH(8), .PARITY_EN(1'b1)) u_dut_par (
        .Clock(Clock), .Reset(Reset), .sin(sin0), .sin_en(en0),
        .Data(d0), .Valid(val0), .Ready(rdy0),
        .ParErr(pe0), .FrameErr(fe0), .Overrun(ov0)
    );

    serial_frame_receiver #(.DATA_WIDTH(8), .PARITY_EN(1'b0)) u_dut_nopar (
        .Clock(Clock), .Reset(Reset), .sin(sin1), .sin_en(en1),
        .Data(d1), .Valid(val1), .Ready(rdy1),
        .ParErr(pe1), .FrameErr(fe1), .Overrun(ov1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change at a negedge; returning at the next negedge leaves outputs of the sampling edge visible.
    task automatic drive(input logic b, input logic en);
        if (tgt == 0) begin
            sin0 = b; en0 = en; sin1 = 1'b0; en1 = 1'b0;
        end else begin
            sin1 = b; en1 = en; sin0 = 1'b0; en0 = 1'b0;
        end
        @(negedge Clock);
    endtask

    task automatic put_bit(input logic b, input logic gap);
        if (gap) drive(~b, 1'b0);
        drive(b, 1'b1);
    endtask

    task automatic send_body(input logic [7:0] w, input logic parbit, input logic with_par, input logic gap);
        put_bit(1'b1, gap);
        for (int i = 0; i < 8; i++) put_bit(w[i], gap);
        if (with_par) put_bit(parbit, gap);
    endtask

    initial begin
        Reset = 1'b1;
        rdy0 = 1'b1; rdy1 = 1'b1;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        Reset = 1'b0;
        chk("rst_valid", val0, 0);
        chk("rst_data", d0, 0);
        chk("rst_parerr", pe0, 0);
        chk("rst_frameerr", fe0, 0);
        chk("rst_overrun", ov0, 0);
        chk("rst_valid_nopar", val1, 0);

        // Good frame 0xA5
        drive(1'b0, 1'b1);
        send_body(8'hA5, 1'b0, 1'b1, 1'b0);
        chk("a5_valid_before_stop", val0, 0);
        put_bit(1'b0, 1'b0);
        chk("a5_valid", val0, 1);
        chk("a5_data", d0, 8'hA5);
        chk("a5_parerr", pe0, 0);
        chk("a5_frameerr", fe0, 0);
        drive(1'b0, 1'b1);
        chk("a5_valid_one_cycle", val0, 0);

        // Parity error
        send_body(8'hA5, 1'b1, 1'b1, 1'b0);
        put_bit(1'b0, 1'b0);
        chk("par_parerr", pe0, 1);
        chk("par_valid", val0, 0);
        drive(1'b0, 1'b1);
        chk("par_pulse_end", pe0, 0);

        // Frame error then good frame
        send_body(8'h3C, 1'b0, 1'b1, 1'b0);
        put_bit(1'b1, 1'b0);
        chk("fe_frameerr", fe0, 1);
        chk("fe_parerr", pe0, 0);
        chk("fe_valid", val0, 0);
        drive(1'b0, 1'b1);
        chk("fe_pulse_end", fe0, 0);
        send_body(8'h01, 1'b1, 1'b1, 1'b0);
        put_bit(1'b0, 1'b0);
        chk("x01_valid", val0, 1);
        chk("x01_data", d0, 8'h01);
        drive(1'b0, 1'b1);

        // New frame landing in the same cycle the held word is taken
        rdy0 = 1'b0;
        send_body(8'h81, 1'b0, 1'b1, 1'b0);
        put_bit(1'b0, 1'b0);
        chk("x81_data", d0, 8'h81);
        send_body(8'h7E, 1'b0, 1'b1, 1'b0);
        chk("x81_held", d0, 8'h81);
        rdy0 = 1'b1;
        put_bit(1'b0, 1'b0);
        chk("x7e_valid", val0, 1);
        chk("x7e_data", d0, 8'h7E);
        chk("x7e_no_overrun", ov0, 0);
        drive(1'b0, 1'b1);
        chk("x7e_consumed", val0, 0);

        // Backpressure and overrun
        rdy0 = 1'b0;
        send_body(8'h11, 1'b0, 1'b1, 1'b0);
        put_bit(1'b0, 1'b0);
        chk("bp_11_valid", val0, 1);
        chk("bp_11_data", d0, 8'h11);
        chk("bp_11_overrun", ov0, 0);
        send_body(8'h22, 1'b0, 1'b1, 1'b0);
        put_bit(1'b0, 1'b0);
        chk("bp_22_valid", val0, 1);
        chk("bp_22_data_kept", d0, 8'h11);
        chk("bp_22_overrun", ov0, 1);
        rdy0 = 1'b1;
        drive(1'b0, 1'b1);
        chk("bp_consumed", val0, 0);
        chk("bp_overrun_sticky", ov0, 1);
        drive(1'b0, 1'b1);
        chk("bp_still_idle", val0, 0);

        // Gapped enable
        send_body(8'h5A, 1'b0, 1'b1, 1'b1);
        put_bit(1'b0, 1'b1);
        chk("gap_valid", val0, 1);
        chk("gap_data", d0, 8'h5A);
        drive(1'b0, 1'b1);

        // Reset mid-frame
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        Reset = 1'b1;
        drive(1'b1, 1'b1);
        Reset = 1'b0;
        chk("mid_rst_valid", val0, 0);
        chk("mid_rst_data", d0, 0);
        chk("mid_rst_overrun", ov0, 0);
        chk("mid_rst_parerr", pe0, 0);
        chk("mid_rst_frameerr", fe0, 0);
        send_body(8'h0F, 1'b0, 1'b1, 1'b0);
        put_bit(1'b0, 1'b0);
        chk("x0f_valid", val0, 1);
        chk("x0f_data", d0, 8'h0F);
        chk("x0f_parerr", pe0, 0);
        drive(1'b0, 1'b1);

        // No-parity build, back-to-back frames
        tgt = 1;
        drive(1'b0, 1'b1);
        send_body(8'hFF, 1'b0, 1'b0, 1'b0);
        put_bit(1'b0, 1'b0);
        chk("np_ff_valid", val1, 1);
        chk("np_ff_data", d1, 8'hFF);
        chk("np_ff_parerr", pe1, 0);
        chk("np_ff_frameerr", fe1, 0);
        send_body(8'h00, 1'b0, 1'b0, 1'b0);
        chk("np_ff_consumed", val1, 0);
        put_bit(1'b0, 1'b0);
        chk("np_00_valid", val1, 1);
        chk("np_00_data", d1, 8'h00);
        chk("np_00_parerr", pe1, 0);
        chk("np_00_frameerr", fe1, 0);
        chk("np_00_overrun", ov1, 0);
        drive(1'b0, 1'b1);
        chk("np_00_consumed", val1, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
